// File: rtl/l1_icache_fetch_queue.sv
// In-order fetch decoupler between the core fetch stage and the L1 icache.
// Tracks up to DEPTH outstanding plus buffered fetches, with a single-cycle flush.
module l1_icache_fetch_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   core_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  core_req_addr_i,
  output logic                   core_req_ready_o,
  output logic                   ic_req_valid_o,
  output logic [ADDR_WIDTH-1:0]  ic_req_addr_o,
  input  logic                   ic_req_ready_i,
  input  logic                   ic_resp_valid_i,
  input  logic [FETCH_WIDTH-1:0] ic_resp_data_i,
  input  logic                   ic_resp_err_i,
  output logic                   core_resp_valid_o,
  input  logic                   core_resp_ready_i,
  output logic [ADDR_WIDTH-1:0]  core_resp_addr_o,
  output logic [FETCH_WIDTH-1:0] core_resp_data_o,
  output logic                   core_resp_err_o,
  output logic                   busy_o
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; valid never depends on ready of the same channel. The icache
  // response channel has no ready and is accepted unconditionally.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDR_WIDTH-1:0]  tag_addr [DEPTH];
  logic [DEPTH-1:0]       tag_kill;
  logic [DEPTH-1:0]       tag_kill_n;
  logic [DEPTH-1:0]       tag_live;
  ptr_t                   tag_off [DEPTH];
  ptr_t                   tag_wr_ptr;
  ptr_t                   tag_rd_ptr;
  cnt_t                   inflight_cnt;
  cnt_t                   inflight_cnt_n;

  logic [ADDR_WIDTH-1:0]  fifo_addr [DEPTH];
  logic [FETCH_WIDTH-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]       fifo_err;
  ptr_t                   fifo_wr_ptr;
  ptr_t                   fifo_rd_ptr;
  cnt_t                   fifo_cnt;
  cnt_t                   fifo_cnt_n;

  logic [CW:0] occupancy;
  logic        room;
  logic        accept;
  logic        resp_pop;
  logic        resp_keep;
  logic        core_pop;

  // Room comes from registered counts only, so a same-cycle core pop
  // frees a slot no earlier than the next cycle.
  assign occupancy = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign room      = occupancy < DEPTH_OCC;

  assign ic_req_valid_o   = rst_ni & core_req_valid_i & room & ~flush_i;
  assign core_req_ready_o = rst_ni & ic_req_ready_i & room & ~flush_i;
  assign ic_req_addr_o    = core_req_addr_i;
  assign accept           = ic_req_valid_o & ic_req_ready_i;

  // A response with nothing in flight is a protocol violation and is dropped.
  assign resp_pop  = ic_resp_valid_i & (inflight_cnt != '0);
  assign resp_keep = resp_pop & ~tag_kill[tag_rd_ptr] & ~flush_i;
  assign core_pop  = core_resp_valid_o & core_resp_ready_i & ~flush_i;

  assign inflight_cnt_n = inflight_cnt + cnt_t'(accept) - cnt_t'(resp_pop);
  assign fifo_cnt_n     = flush_i ? '0 : (fifo_cnt + cnt_t'(resp_keep) - cnt_t'(core_pop));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tag_off[i] = ptr_t'(i) - tag_rd_ptr;
    end
  end

  always_comb begin
    tag_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tag_live[i] = {1'b0, tag_off[i]} < inflight_cnt;
    end
  end

  // Flush marks only live entries; accept is blocked during flush, so the
  // two updates never target the same cycle.
  always_comb begin
    tag_kill_n = tag_kill;
    if (flush_i) begin
      tag_kill_n = tag_kill | tag_live;
    end
    if (accept) begin
      tag_kill_n[tag_wr_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wr_ptr   <= '0;
      tag_rd_ptr   <= '0;
      inflight_cnt <= '0;
      tag_kill     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_addr[i] <= '0;
      end
    end else begin
      if (accept) begin
        tag_addr[tag_wr_ptr] <= core_req_addr_i;
        tag_wr_ptr           <= tag_wr_ptr + ptr_t'(1);
      end
      if (resp_pop) begin
        tag_rd_ptr <= tag_rd_ptr + ptr_t'(1);
      end
      tag_kill     <= tag_kill_n;
      inflight_cnt <= inflight_cnt_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_cnt    <= '0;
      fifo_err    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (resp_keep) begin
        fifo_addr[fifo_wr_ptr] <= tag_addr[tag_rd_ptr];
        fifo_data[fifo_wr_ptr] <= ic_resp_data_i;
        fifo_err[fifo_wr_ptr]  <= ic_resp_err_i;
      end
      if (flush_i) begin
        fifo_wr_ptr <= '0;
        fifo_rd_ptr <= '0;
      end else begin
        if (resp_keep) begin
          fifo_wr_ptr <= fifo_wr_ptr + ptr_t'(1);
        end
        if (core_pop) begin
          fifo_rd_ptr <= fifo_rd_ptr + ptr_t'(1);
        end
      end
      fifo_cnt <= fifo_cnt_n;
    end
  end

  assign core_resp_valid_o = fifo_cnt != '0;
  assign core_resp_addr_o  = fifo_addr[fifo_rd_ptr];
  assign core_resp_data_o  = fifo_data[fifo_rd_ptr];
  assign core_resp_err_o   = fifo_err[fifo_rd_ptr];
  assign busy_o            = inflight_cnt != '0;

endmodule

// File: tb/tb_l1_icache_fetch_queue.sv
// Bench for l1_icache_fetch_queue: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_l1_icache_fetch_queue;
  localparam int AW    = 32;
  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int SBW   = AW + FW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          core_req_valid = 1'b0;
  logic [AW-1:0] core_req_addr = '0;
  logic          core_req_ready;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_addr;
  logic          ic_req_ready = 1'b0;
  logic          ic_resp_valid = 1'b0;
  logic [FW-1:0] ic_resp_data = '0;
  logic          ic_resp_err = 1'b0;
  logic          core_resp_valid;
  logic          core_resp_ready = 1'b0;
  logic [AW-1:0] core_resp_addr;
  logic [FW-1:0] core_resp_data;
  logic          core_resp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [SBW-1:0] exp_q[$];
  logic [AW-1:0]  infl_addr_q[$];
  logic           infl_kill_q[$];
  logic [SBW-1:0] delivered_log[$];
  logic [SBW-1:0] dut_log[$];

  typedef struct {
    logic          crv;
    logic [AW-1:0] cra;
    logic          icr;
    logic          rv;
    logic [FW-1:0] rd;
    logic          re;
    logic          cpr;
    logic          fl;
    logic          e_irv;
    logic          e_crr;
    logic          e_cv;
    logic [AW-1:0] e_caddr;
    logic [FW-1:0] e_cdata;
    logic          e_busy;
  } vec_t;
  vec_t vecs[12];

  l1_icache_fetch_queue #(.ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .core_req_valid_i(core_req_valid), .core_req_addr_i(core_req_addr),
    .core_req_ready_o(core_req_ready),
    .ic_req_valid_o(ic_req_valid), .ic_req_addr_o(ic_req_addr), .ic_req_ready_i(ic_req_ready),
    .ic_resp_valid_i(ic_resp_valid), .ic_resp_data_i(ic_resp_data), .ic_resp_err_i(ic_resp_err),
    .core_resp_valid_o(core_resp_valid), .core_resp_ready_i(core_resp_ready),
    .core_resp_addr_o(core_resp_addr), .core_resp_data_o(core_resp_data),
    .core_resp_err_o(core_resp_err), .busy_o(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; core_req_valid = 1'b0; core_req_addr = '0; ic_req_ready = 1'b0;
    ic_resp_valid = 1'b0; ic_resp_data = '0; ic_resp_err = 1'b0; core_resp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_resp_valid"}, core_resp_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_core_resp_addr"}, core_resp_addr, '0);
    check({tag, "_core_resp_data"}, core_resp_data, '0);
    check({tag, "_core_resp_err"}, core_resp_err, 1'b0);
    check({tag, "_core_req_ready"}, core_req_ready, 1'b0);
    check({tag, "_ic_req_valid"}, ic_req_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0; core_req_valid = 1'b1; core_req_addr = 32'hFFFF_0000; ic_req_ready = 1'b1;
    ic_resp_valid = 1'b1; ic_resp_data = '1; ic_resp_err = 1'b1; core_resp_ready = 1'b1;
    exp_q.delete(); infl_addr_q.delete(); infl_kill_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // driver: set inputs after the edge, then move to the sampling point
  task automatic apply(input logic crv, input logic [AW-1:0] cra, input logic icr,
                       input logic rv, input logic [FW-1:0] rd, input logic re,
                       input logic cpr, input logic fl);
    core_req_valid = crv; core_req_addr = cra; ic_req_ready = icr;
    ic_resp_valid = rv; ic_resp_data = rd; ic_resp_err = re;
    core_resp_ready = cpr; flush = fl;
    @(negedge clk);
  endtask

  // scoreboard: compare against the model, then step the model across the edge
  task automatic advance();
    logic          room;
    logic          e_cv;
    logic          k;
    logic [AW-1:0] a;
    room = (infl_addr_q.size() + exp_q.size()) < DEPTH;
    e_cv = exp_q.size() != 0;
    check("ic_req_valid", ic_req_valid, core_req_valid & room & ~flush);
    check("core_req_ready", core_req_ready, ic_req_ready & room & ~flush);
    check("ic_req_addr", ic_req_addr, core_req_addr);
    check("busy", busy, infl_addr_q.size() != 0);
    check("core_resp_valid", core_resp_valid, e_cv);
    if (e_cv) check("core_resp_bundle", {core_resp_addr, core_resp_data, core_resp_err}, exp_q[0]);
    if (core_resp_valid & core_resp_ready & ~flush)
      dut_log.push_back({core_resp_addr, core_resp_data, core_resp_err});
    if (e_cv & core_resp_ready & ~flush) delivered_log.push_back(exp_q.pop_front());
    if (flush) begin
      exp_q.delete();
      foreach (infl_kill_q[i]) infl_kill_q[i] = 1'b1;
    end
    if (ic_resp_valid && infl_addr_q.size() != 0) begin
      a = infl_addr_q.pop_front();
      k = infl_kill_q.pop_front();
      if (!k && !flush) exp_q.push_back({a, ic_resp_data, ic_resp_err});
    end
    if (core_req_valid & ic_req_ready & room & ~flush) begin
      infl_addr_q.push_back(core_req_addr);
      infl_kill_q.push_back(1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n_acc;
    int n_v;
    int base;
    logic [SBW-1:0] want;

    // single fetch (3-cycle latency), then flush against two buffered bundles
    vecs[0]  = '{1'b1, 32'h1000, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,  1'b0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,  1'b1};
    vecs[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,  1'b1};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,  1'b1};
    vecs[4]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h13, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,  1'b0};
    vecs[6]  = '{1'b1, 32'h2000, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,  1'b0};
    vecs[7]  = '{1'b1, 32'h2004, 1'b1, 1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,  1'b1};
    vecs[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hA,  1'b1};
    vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'hA,  1'b0};
    vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,  1'b0};
    vecs[11] = '{1'b1, 32'h2008, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,  1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].crv, vecs[i].cra, vecs[i].icr, vecs[i].rv, vecs[i].rd, vecs[i].re,
            vecs[i].cpr, vecs[i].fl);
      check($sformatf("vec%0d_ic_req_valid", i), ic_req_valid, vecs[i].e_irv);
      check($sformatf("vec%0d_core_req_ready", i), core_req_ready, vecs[i].e_crr);
      check($sformatf("vec%0d_core_resp_valid", i), core_resp_valid, vecs[i].e_cv);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_cv) begin
        check($sformatf("vec%0d_core_resp_addr", i), core_resp_addr, vecs[i].e_caddr);
        check($sformatf("vec%0d_core_resp_data", i), core_resp_data, vecs[i].e_cdata);
      end
      advance();
    end

    // full: core stalled, six back-to-back requests, 1-cycle icache latency
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      apply(1'b1, 32'h3000 + 32'(4 * c), 1'b1, (c >= 1 && c <= 4), 32'h300 + 32'(c), 1'b0, 1'b0, 1'b0);
      if (core_req_ready) n_acc++;
      if (c >= 4) check($sformatf("full_ready_low_req%0d", c + 1), core_req_ready, 1'b0);
      advance();
    end
    check("full_accept_count", n_acc, 4);
    apply(1'b1, 32'h3100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("full_pop_same_cycle_ready", core_req_ready, 1'b0);
    advance();
    apply(1'b1, 32'h3100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("full_accept_after_pop", core_req_ready, 1'b1);
    advance();

    // flush with three fetches in flight, then one new fetch
    do_reset();
    base = dut_log.size();
    for (int c = 0; c < 12; c++) begin
      if (c < 3) apply(1'b1, 32'h100 + 32'(4 * c), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      else if (c == 3) apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      else if (c == 4) apply(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      else if (c <= 8) apply(1'b0, 32'h0, 1'b0, 1'b1, 32'hD0 + 32'(c - 5), 1'b0, 1'b1, 1'b0);
      else apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (c == 8) check("flush_busy_before_last_resp", busy, 1'b1);
      if (c == 9) check("flush_busy_after_last_resp", busy, 1'b0);
      advance();
    end
    check("flush_delivered_count", dut_log.size() - base, 1);
    if (dut_log.size() > base) check("flush_delivered_bundle", dut_log[base], {32'h200, 32'hD3, 1'b0});

    // streaming with an error on the fifth response
    do_reset();
    base = dut_log.size();
    n_v = 0;
    for (int c = 0; c < 10; c++) begin
      apply(c < 8, 32'h4000 + 32'(4 * c), 1'b1, (c >= 1 && c <= 8), 32'h1000 + 32'(c - 1),
            (c == 5), 1'b1, 1'b0);
      if (c >= 2 && core_resp_valid) n_v++;
      advance();
    end
    check("stream_valid_cycles", n_v, 8);
    check("stream_delivered_count", dut_log.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      want = {32'h4000 + 32'(4 * k), 32'h1000 + 32'(k), (k == 4)};
      if (dut_log.size() > base + k) check($sformatf("stream_bundle%0d", k), dut_log[base + k], want);
    end

    // asynchronous reset with two fetches in flight and one buffered bundle
    do_reset();
    apply(1'b1, 32'h480, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); advance();
    apply(1'b1, 32'h500, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0); advance();
    apply(1'b1, 32'h504, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); advance();
    core_req_valid = 1'b1; core_req_addr = 32'h508; ic_req_ready = 1'b1;
    ic_resp_valid = 1'b0; core_resp_ready = 1'b0; flush = 1'b0;
    #2;
    check("arst_pre_valid", core_resp_valid, 1'b1);
    check("arst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    exp_q.delete(); infl_addr_q.delete(); infl_kill_q.delete();
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = dut_log.size();
    apply(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); advance();
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1, 1'b0); advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); advance();
    check("arst_resume_count", dut_log.size() - base, 1);
    if (dut_log.size() > base) check("arst_resume_bundle", dut_log[base], {32'h600, 32'h66, 1'b0});

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            (infl_addr_q.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0),
            $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      advance();
    end
    clear_inputs();

    check("total_delivered_count", dut_log.size(), delivered_log.size());
    for (int i = 0; i < dut_log.size() && i < delivered_log.size(); i++) begin
      if (dut_log[i] !== delivered_log[i])
        check($sformatf("delivered_order%0d", i), dut_log[i], delivered_log[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
